// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MEM_WAIT    = 2'd1,
    MULDIV_WAIT = 2'd2
  } ctrl_state_e;

  localparam int MAX_WAIT_DEF = 64;
  localparam int PERF_W       = 32;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and per-stage hold/bubble/flush controls of the stall controller.
interface pipeline_stall_controller_if;
  import pipeline_ctrl_pkg::*;

  logic              LU_HAZARD;
  logic              BRANCH_TAKEN_EX;
  logic              MULDIV_START_EX;
  logic              MULDIV_DONE;
  logic              DMEM_BUSY;
  logic              PC_HOLD;
  logic              IF_ID_HOLD;
  logic              ID_EX_HOLD;
  logic              EX_MEM_HOLD;
  logic              MEM_WB_BUBBLE;
  logic              EX_MEM_BUBBLE;
  logic              ID_EX_BUBBLE;
  logic              IF_ID_FLUSH;
  logic              WAIT_TIMEOUT;
  logic [PERF_W-1:0] STALL_CYCLES;
  logic [PERF_W-1:0] FLUSH_COUNT;

  modport master (
    input  LU_HAZARD, BRANCH_TAKEN_EX, MULDIV_START_EX,
    input  MULDIV_DONE, DMEM_BUSY,
    output PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD,
    output MEM_WB_BUBBLE, EX_MEM_BUBBLE, ID_EX_BUBBLE,
    output IF_ID_FLUSH, WAIT_TIMEOUT, STALL_CYCLES, FLUSH_COUNT
  );

  modport slave (
    output LU_HAZARD, BRANCH_TAKEN_EX, MULDIV_START_EX,
    output MULDIV_DONE, DMEM_BUSY,
    input  PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD,
    input  MEM_WB_BUBBLE, EX_MEM_BUBBLE, ID_EX_BUBBLE,
    input  IF_ID_FLUSH, WAIT_TIMEOUT, STALL_CYCLES, FLUSH_COUNT
  );

endinterface

// File: rtl/pipeline_stall_controller_stall_watchdog.sv
// Saturating wait-cycle counter with a sticky timeout flag.
module stall_watchdog #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic in_wait,
  input  logic clr,
  output logic timeout
);

  localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (clr)
        cnt <= '0;
      else if (in_wait && cnt != MAXV)
        cnt <= cnt + 1'b1;
      // flag rises on the edge that completes the MAX_WAIT-th wait cycle
      if (in_wait && cnt >= MAXV - 1'b1)
        timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MAX_WAIT   = MAX_WAIT_DEF,
  parameter int WAIT_CNT_W = 8
) (
  input logic CLK,
  input logic RESET,
  pipeline_stall_controller_if.master bus
);

  ctrl_state_e state, next_state;
  logic pending, mul_wait;
  logic c_mem, c_mul, c_exit, c_br, c_lu;
  logic pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic mem_wb_bubble, ex_mem_bubble;
  logic id_ex_bubble, if_id_flush;
  logic in_wait, wd_clr, timeout;

  // pending remembers a MUL/DIV caught under a memory freeze
  assign mul_wait = !bus.MULDIV_DONE &&
    (state == MULDIV_WAIT ||
     (state == MEM_WAIT && pending) ||
     (state == RUN && bus.MULDIV_START_EX));

  assign c_mem  = bus.DMEM_BUSY;
  assign c_mul  = !bus.DMEM_BUSY && mul_wait;
  assign c_exit = !bus.DMEM_BUSY && !mul_wait && state != RUN;
  assign c_br   = !bus.DMEM_BUSY && !mul_wait && state == RUN &&
                  bus.BRANCH_TAKEN_EX;
  assign c_lu   = !bus.DMEM_BUSY && !mul_wait && state == RUN &&
                  !bus.BRANCH_TAKEN_EX && bus.LU_HAZARD;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= RUN;
      pending <= 1'b0;
    end else begin
      state <= next_state;
      if (c_mem && state != MEM_WAIT)
        pending <= mul_wait;
    end
  end

  always_comb begin
    next_state    = state;
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    ex_mem_bubble = 1'b0;
    id_ex_bubble  = 1'b0;
    if_id_flush   = 1'b0;
    unique case (1'b1)
      c_mem: begin
        pc_hold       = 1'b1;
        if_id_hold    = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
        next_state    = MEM_WAIT;
      end
      c_mul: begin
        pc_hold       = 1'b1;
        if_id_hold    = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_bubble = 1'b1;
        next_state    = MULDIV_WAIT;
      end
      c_exit: next_state = RUN;
      c_br: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      c_lu: begin
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_wait = state != RUN;
  assign wd_clr  = next_state == RUN;

  stall_watchdog #(
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (WAIT_CNT_W)
  ) u_wd (
    .CLK    (CLK),
    .RESET  (RESET),
    .in_wait(in_wait),
    .clr    (wd_clr),
    .timeout(timeout)
  );

  assign bus.PC_HOLD       = pc_hold;
  assign bus.IF_ID_HOLD    = if_id_hold;
  assign bus.ID_EX_HOLD    = id_ex_hold;
  assign bus.EX_MEM_HOLD   = ex_mem_hold;
  assign bus.MEM_WB_BUBBLE = mem_wb_bubble;
  assign bus.EX_MEM_BUBBLE = ex_mem_bubble;
  assign bus.ID_EX_BUBBLE  = id_ex_bubble;
  assign bus.IF_ID_FLUSH   = if_id_flush;
  assign bus.WAIT_TIMEOUT  = timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q, flush_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_hold) stall_q <= stall_q + 1'b1;
      if (c_br)    flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.STALL_CYCLES = stall_q;
  assign bus.FLUSH_COUNT  = flush_q;
`else
  assign bus.STALL_CYCLES = '0;
  assign bus.FLUSH_COUNT  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MAX_WAIT=8).
module tb_pipeline_stall_controller;
  import pipeline_ctrl_pkg::*;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // control vector bit order:
  // PC_HOLD IF_ID_HOLD ID_EX_HOLD EX_MEM_HOLD
  // MEM_WB_BUBBLE EX_MEM_BUBBLE ID_EX_BUBBLE IF_ID_FLUSH
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b1100_0010;
  localparam logic [7:0] C_BR   = 8'b0000_0011;
  localparam logic [7:0] C_MUL  = 8'b1110_0100;
  localparam logic [7:0] C_MEM  = 8'b1111_1000;

  logic CLK = 1'b0;
  logic RESET;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] ctl;

  pipeline_stall_controller_if bus ();

  pipeline_stall_controller #(
    .MAX_WAIT  (8),
    .WAIT_CNT_W(8)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.master)
  );

  always #5 CLK = ~CLK;

  assign ctl = {bus.PC_HOLD, bus.IF_ID_HOLD, bus.ID_EX_HOLD,
                bus.EX_MEM_HOLD, bus.MEM_WB_BUBBLE, bus.EX_MEM_BUBBLE,
                bus.ID_EX_BUBBLE, bus.IF_ID_FLUSH};

  task automatic go;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in;
    bus.LU_HAZARD       = 1'b0;
    bus.BRANCH_TAKEN_EX = 1'b0;
    bus.MULDIV_START_EX = 1'b0;
    bus.MULDIV_DONE     = 1'b0;
    bus.DMEM_BUSY       = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge CLK);
    idle_in();
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    go();
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge CLK);
    n_chk++;
    if (ctl !== C_NONE || bus.WAIT_TIMEOUT !== 1'b0 ||
        bus.STALL_CYCLES !== 32'd0 || bus.FLUSH_COUNT !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_idle: ctl=%b to=%b got, 0 required",
               ctl, bus.WAIT_TIMEOUT);
    end
    go();
    bus.MULDIV_START_EX = 1'b1;
    go();
    bus.MULDIV_START_EX = 1'b0;
    repeat (5) go();
    @(negedge CLK);
    n_chk++;
    if (dut.u_wd.cnt !== 8'd5 || dut.state !== MULDIV_WAIT ||
        ctl !== C_MUL) begin
      n_fail++;
      $display("FAIL reset_pre: cnt=%0d st=%0d ctl=%b, need 5 2 %b",
               dut.u_wd.cnt, dut.state, ctl, C_MUL);
    end
    RESET = 1'b1;
    #1;
    n_chk++;
    if (ctl !== C_NONE || dut.state !== RUN || dut.u_wd.cnt !== 8'd0 ||
        bus.STALL_CYCLES !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: ctl=%b st=%0d cnt=%0d, need 0 0 0",
               ctl, dut.state, dut.u_wd.cnt);
    end
    #1;
    RESET = 1'b0;
  endtask

  task automatic test_load_use;
    do_reset();
    bus.LU_HAZARD = 1'b1;
    @(negedge CLK);
    n_chk++;
    if (ctl !== C_LU) begin
      n_fail++;
      $display("FAIL lu_stall: ctl=%b, need %b", ctl, C_LU);
    end
    go();
    bus.LU_HAZARD = 1'b0;
    @(negedge CLK);
    n_chk++;
    if (ctl !== C_NONE || dut.state !== RUN) begin
      n_fail++;
      $display("FAIL lu_release: ctl=%b st=%0d, need 0 0", ctl, dut.state);
    end
    n_chk++;
    if (bus.STALL_CYCLES !== (PERF ? 32'd1 : 32'd0)) begin
      n_fail++;
      $display("FAIL lu_stall_cnt: got %0d need %0d",
               bus.STALL_CYCLES, PERF ? 1 : 0);
    end
  endtask

  task automatic test_branch;
    do_reset();
    bus.BRANCH_TAKEN_EX = 1'b1;
    bus.LU_HAZARD       = 1'b1;
    @(negedge CLK);
    n_chk++;
    if (ctl !== C_BR) begin
      n_fail++;
      $display("FAIL br_flush: ctl=%b, need %b", ctl, C_BR);
    end
    go();
    idle_in();
    @(negedge CLK);
    n_chk++;
    if (ctl !== C_NONE || dut.state !== RUN) begin
      n_fail++;
      $display("FAIL br_after: ctl=%b st=%0d", ctl, dut.state);
    end
    n_chk++;
    if (bus.FLUSH_COUNT !== (PERF ? 32'd1 : 32'd0) ||
        bus.STALL_CYCLES !== 32'd0) begin
      n_fail++;
      $display("FAIL br_counts: flush=%0d stall=%0d need %0d 0",
               bus.FLUSH_COUNT, bus.STALL_CYCLES, PERF ? 1 : 0);
    end
  endtask

  task automatic test_muldiv;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.MULDIV_START_EX = (i == 0);
      @(negedge CLK);
      n_chk++;
      if (ctl !== C_MUL) begin
        n_fail++;
        $display("FAIL md_stall%0d: ctl=%b need %b", i, ctl, C_MUL);
      end
      go();
    end
    bus.MULDIV_START_EX = 1'b0;
    bus.MULDIV_DONE     = 1'b1;
    @(negedge CLK);
    n_chk++;
    if (ctl !== C_NONE || dut.state !== MULDIV_WAIT) begin
      n_fail++;
      $display("FAIL md_done: ctl=%b st=%0d need 0 2", ctl, dut.state);
    end
    go();
    bus.MULDIV_DONE = 1'b0;
    @(negedge CLK);
    n_chk++;
    if (ctl !== C_NONE || dut.state !== RUN ||
        bus.STALL_CYCLES !== (PERF ? 32'd4 : 32'd0)) begin
      n_fail++;
      $display("FAIL md_after: ctl=%b st=%0d stall=%0d",
               ctl, dut.state, bus.STALL_CYCLES);
    end
    bus.MULDIV_START_EX = 1'b1;
    bus.MULDIV_DONE     = 1'b1;
    @(negedge CLK);
    n_chk++;
    if (ctl !== C_NONE) begin
      n_fail++;
      $display("FAIL md_same_cycle: ctl=%b need 0", ctl);
    end
    go();
    idle_in();
    @(negedge CLK);
    n_chk++;
    if (dut.state !== RUN || ctl !== C_NONE) begin
      n_fail++;
      $display("FAIL md_same_state: st=%0d ctl=%b need 0 0", dut.state, ctl);
    end
  endtask

  task automatic test_dmem_in_muldiv;
    do_reset();
    bus.MULDIV_START_EX = 1'b1;
    go();
    bus.MULDIV_START_EX = 1'b0;
    @(negedge CLK);
    n_chk++;
    if (ctl !== C_MUL || dut.state !== MULDIV_WAIT) begin
      n_fail++;
      $display("FAIL dm_pre: ctl=%b st=%0d", ctl, dut.state);
    end
    go();
    for (int i = 0; i < 3; i++) begin
      bus.DMEM_BUSY = 1'b1;
      @(negedge CLK);
      n_chk++;
      if (ctl !== C_MEM) begin
        n_fail++;
        $display("FAIL dm_freeze%0d: ctl=%b need %b", i, ctl, C_MEM);
      end
      go();
    end
    bus.DMEM_BUSY = 1'b0;
    @(negedge CLK);
    n_chk++;
    if (ctl !== C_MUL || dut.state !== MEM_WAIT) begin
      n_fail++;
      $display("FAIL dm_release: ctl=%b st=%0d need %b 1",
               ctl, dut.state, C_MUL);
    end
    go();
    @(negedge CLK);
    n_chk++;
    if (dut.state !== MULDIV_WAIT || ctl !== C_MUL) begin
      n_fail++;
      $display("FAIL dm_back_md: st=%0d ctl=%b need 2", dut.state, ctl);
    end
    go();
    bus.MULDIV_DONE = 1'b1;
    go();
    bus.MULDIV_DONE = 1'b0;
    @(negedge CLK);
    n_chk++;
    if (dut.state !== RUN || bus.WAIT_TIMEOUT !== 1'b0 ||
        bus.STALL_CYCLES !== (PERF ? 32'd7 : 32'd0)) begin
      n_fail++;
      $display("FAIL dm_end: st=%0d to=%b stall=%0d need 0 0 %0d",
               dut.state, bus.WAIT_TIMEOUT, bus.STALL_CYCLES, PERF ? 7 : 0);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.DMEM_BUSY = 1'b1;
      @(negedge CLK);
      n_chk++;
      if (ctl !== C_MEM || bus.WAIT_TIMEOUT !== (i >= 9)) begin
        n_fail++;
        $display("FAIL to_busy%0d: ctl=%b to=%b need to=%b",
                 i, ctl, bus.WAIT_TIMEOUT, (i >= 9));
      end
      go();
    end
    bus.DMEM_BUSY = 1'b0;
    @(negedge CLK);
    n_chk++;
    if (ctl !== C_NONE || bus.WAIT_TIMEOUT !== 1'b1 ||
        dut.u_wd.cnt !== 8'd8) begin
      n_fail++;
      $display("FAIL to_release: ctl=%b to=%b cnt=%0d need 0 1 8",
               ctl, bus.WAIT_TIMEOUT, dut.u_wd.cnt);
    end
    repeat (3) go();
    @(negedge CLK);
    n_chk++;
    if (bus.WAIT_TIMEOUT !== 1'b1 || dut.state !== RUN ||
        dut.u_wd.cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL to_sticky: to=%b st=%0d cnt=%0d need 1 0 0",
               bus.WAIT_TIMEOUT, dut.state, dut.u_wd.cnt);
    end
    do_reset();
    @(negedge CLK);
    n_chk++;
    if (bus.WAIT_TIMEOUT !== 1'b0) begin
      n_fail++;
      $display("FAIL to_cleared: to=%b need 0", bus.WAIT_TIMEOUT);
    end
  endtask

  initial begin
    RESET = 1'b1;
    idle_in();
    test_reset();
    test_load_use();
    test_branch();
    test_muldiv();
    test_dmem_in_muldiv();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32IM pipeline.
- Combines the load-use hazard flag, taken-branch redirect from EX, multi-cycle MUL/DIV busy and data-memory wait into one consistent set of per-stage hold/bubble/flush controls.
- Holds a small FSM for multi-cycle waits and a watchdog counter that flags a hung wait.
- Sits beside the hazard detection and forwarding units; drives the PC and all pipeline-register enables.

Parameters:
- MAX_WAIT, 64, wait-state cycles before WAIT_TIMEOUT is raised (1..255).
- WAIT_CNT_W, 8, width of the watchdog counter; must hold MAX_WAIT.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- LU_HAZARD  input  1  load-use hazard between the ID and EX instructions.
- BRANCH_TAKEN_EX  input  1  EX resolved a taken branch/jump; IF and ID hold wrong-path instructions.
- MULDIV_START_EX  input  1  EX holds a MUL/DIV op that has started this cycle.
- MULDIV_DONE  input  1  MUL/DIV result valid this cycle.
- DMEM_BUSY  input  1  data memory cannot complete the MEM-stage access this cycle.
- PC_HOLD  output  1  PC register keeps its value.
- IF_ID_HOLD  output  1  IF/ID register keeps its value.
- ID_EX_HOLD  output  1  ID/EX register keeps its value.
- EX_MEM_HOLD  output  1  EX/MEM register keeps its value.
- MEM_WB_BUBBLE  output  1  MEM/WB loads a NOP (write-enables cleared).
- EX_MEM_BUBBLE  output  1  EX/MEM loads a NOP.
- ID_EX_BUBBLE  output  1  ID/EX loads a NOP.
- IF_ID_FLUSH  output  1  IF/ID loads a NOP.
- WAIT_TIMEOUT  output  1  sticky watchdog error.
- STALL_CYCLES  output  32  count of cycles with PC_HOLD=1.
- FLUSH_COUNT  output  32  count of branch flushes.

Behaviour:
- Reset: state=RUN, watchdog=0, WAIT_TIMEOUT=0, counters=0. Control outputs are combinational from state and inputs, so all are 0 in RUN with idle inputs. Async assertion mid-wait aborts to RUN immediately.
- FSM states: RUN, MEM_WAIT, MULDIV_WAIT. All transitions occur on the rising CLK edge.
- Priority within a cycle, highest first: DMEM_BUSY > MUL/DIV wait > BRANCH_TAKEN_EX > LU_HAZARD.
- DMEM_BUSY=1 (any state):
  - PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_BUBBLE all =1.
  - Next state MEM_WAIT; the FSM stays there while DMEM_BUSY=1.
  - On the first cycle with DMEM_BUSY=0: holds released that same cycle; next state is MULDIV_WAIT if a MUL/DIV was pending when the wait began, else RUN.
- MUL/DIV:
  - RUN with MULDIV_START_EX=1 and MULDIV_DONE=0: PC/IF_ID/ID_EX/EX_MEM_HOLD=0 is not allowed; instead PC_HOLD=IF_ID_HOLD=ID_EX_HOLD=1 and EX_MEM_BUBBLE=1. Next state MULDIV_WAIT.
  - START and DONE in the same cycle: no stall.
  - MULDIV_WAIT: same outputs until MULDIV_DONE=1. On the DONE cycle all holds drop, EX_MEM captures the result, next state RUN.
- BRANCH_TAKEN_EX=1 in RUN with no higher-priority condition:
  - IF_ID_FLUSH=1 and ID_EX_BUBBLE=1; PC not held, so the target loads.
  - LU_HAZARD is ignored, because the ID instruction is wrong-path.
  - FLUSH_COUNT increments. No state change.
- LU_HAZARD=1 alone in RUN: PC_HOLD=IF_ID_HOLD=1, ID_EX_BUBBLE=1, exactly one cycle per assertion. No state change.
- BRANCH_TAKEN_EX and LU_HAZARD are ignored outside RUN.
- Watchdog:
  - Increments every cycle in MEM_WAIT or MULDIV_WAIT; clears on entering RUN.
  - Saturates at MAX_WAIT; reaching it sets WAIT_TIMEOUT=1 until RESET.
  - Stalling continues after timeout.
- STALL_CYCLES increments whenever PC_HOLD=1. Both counters wrap at 2^32.

Optional Feature:
- PIPE_PERF_CNT_EN defined: STALL_CYCLES and FLUSH_COUNT are implemented as above.
- Not defined: both ports are driven constant 0 and the counters are not instantiated. All other behaviour is identical.

Decomposition:
- Shared package pipeline_ctrl_pkg:
  - FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, MULDIV_WAIT=2'd2).
  - Default MAX_WAIT constant.
  - Perf-counter width constant (32).
- One natural sub-module: stall_watchdog. It owns the counter, saturation and the sticky WAIT_TIMEOUT; inputs are CLK, RESET, an in-wait flag and the clear condition.

Test Plan:
- Reset mid MULDIV_WAIT (watchdog=5) → next sample: all controls 0, state RUN, watchdog 0.
- LU_HAZARD=1 for 1 cycle in RUN → PC_HOLD=IF_ID_HOLD=ID_EX_BUBBLE=1 for exactly that cycle; STALL_CYCLES +1.
- BRANCH_TAKEN_EX=1 and LU_HAZARD=1 together → IF_ID_FLUSH=ID_EX_BUBBLE=1, PC_HOLD=0, FLUSH_COUNT +1.
- MULDIV_START_EX=1, MULDIV_DONE=1 four cycles later → PC/IF_ID/ID_EX_HOLD=1 and EX_MEM_BUBBLE=1 for 4 cycles, released on the DONE cycle.
  - Repeat with START and DONE in the same cycle → no stall.
- DMEM_BUSY=1 for 3 cycles during MULDIV_WAIT → full freeze with MEM_WB_BUBBLE=1 for 3 cycles, then return to MULDIV_WAIT.
- MAX_WAIT=8, DMEM_BUSY held 10 cycles → WAIT_TIMEOUT rises after the 8th wait cycle and stays 1 after DMEM_BUSY drops, until RESET.
